fairy_mem_stage: RTL and testbench
==================================

Name: fairy_mem_stage

Overview:
- Memory-access pipeline stage sitting directly after fairy_exe_stage, and before writeback.
- Takes the execute result (effective address or ALU value), the store operand and the instruction word.
- For loads and stores it runs a request/acknowledge transaction on the data-memory port. It then formats load data (byte/half extraction, sign/zero extension) and registers everything to writeback.
- Detects misaligned load/store addresses and raises stall_o while a transaction is outstanding.

Parameters:
- DM_TIMEOUT, 0, cycles to wait for dm_ack before forcing completion with rdata=0; 0 means wait forever.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- exception_i  in  1  flush pipeline
- eret_i  in  1  flush pipeline
- data_i  in  64  execute result; [31:0] = address / ALU value, [63:32] = HI part
- op1_i  in  32  store data (rt)
- inst_i  in  32  instruction word
- pc_i  in  32  instruction PC
- reg_waddr_i  in  5  destination register
- reg_we_i  in  1  register write enable
- hilo_we_i  in  2  HI/LO write enables
- overflow_i  in  1  arithmetic overflow from execute
- illegal_inst_i  in  1  illegal-instruction flag
- delayslot_i  in  1  delay-slot flag
- dm_req  out  1  memory request
- dm_wr  out  1  1 = write
- dm_addr  out  32  word-aligned address
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-aligned write data
- dm_ack  in  1  request accepted / read data valid
- dm_rdata  in  32  read data
- stall_o  out  1  hold upstream
- data_o  out  64  writeback data
- reg_waddr_o  out  5  registered destination register
- reg_we_o  out  1  registered write enable
- hilo_we_o  out  2  registered HI/LO write enables
- pc_o  out  32  registered PC
- inst_o  out  32  registered instruction
- delayslot_o  out  1  registered delay-slot flag
- overflow_o  out  1  registered overflow flag
- illegal_inst_o  out  1  registered illegal-instruction flag
- unaligned_addr_o  out  1  address-error flag
- badvaddr_o  out  32  faulting address

Behaviour:
- Reset: all registered outputs are 0, dm_req=0, state=IDLE. Reset is asynchronous and active-low, and takes effect mid-transaction; any pending ack is ignored after reset.
- States: IDLE, WAIT, DRAIN.
- Non-memory instruction in IDLE:
  - 1-cycle latency; all inputs are registered to the outputs.
  - data_o = data_i.
  - reg_we_o = reg_we_i & ~overflow_i.
  - stall_o = 0.
- Misalignment (IDLE):
  - LH/LHU/SH fault when addr[0] ≠ 0.
  - LW/SW fault when addr[1:0] ≠ 0.
  - On a fault: no request is issued. Next cycle unaligned_addr_o=1, badvaddr_o=address, reg_we_o=0.
- Aligned memory op in IDLE:
  - stall_o=1; next state WAIT; dm_req=1 from the next cycle.
  - dm_addr = {addr[31:2], 2'b00}.
  - dm_wr = store.
  - Store lanes: SB replicates op1[7:0] across 4 lanes with be = 1 << addr[1:0]. SH replicates op1[15:0] with be = 0011 or 1100. SW uses be = 1111. Loads use be = 1111.
- WAIT:
  - dm_req and all dm_* outputs are held stable.
  - stall_o = ~dm_ack.
  - On dm_ack: register the formatted result, return to IDLE, deassert dm_req the following cycle.
  - Load formatting: LB/LBU select byte addr[1:0], sign/zero extended. LH/LHU select the half addr[1], sign/zero extended. LW takes the full word.
  - Stores complete with reg_we_o=0.
  - data_o[63:32] = 0 for loads.
- Upstream holds all inputs stable while stall_o=1. The output stage emits a bubble (reg_we_o=0, hilo_we_o=0, inst_o=0) on every stalled cycle.
- Flush (exception_i | eret_i):
  - Output registers are cleared next cycle, regardless of state.
  - In IDLE, no request is started.
  - In WAIT without ack: go to DRAIN, keep dm_req until dm_ack, discard data, then go to IDLE. stall_o=0 in DRAIN.
  - A memory op arriving during DRAIN waits (stall_o=1) until DRAIN exits.
  - Flush in the same cycle as dm_ack: data is discarded, go to IDLE.
- Timeout: if DM_TIMEOUT > 0 and the wait count reaches DM_TIMEOUT, complete as if acked with rdata=0. The counter resets on each new request.
- illegal_inst_i=1 or overflow_i=1 suppresses any memory request and the register write; the flags pass through unchanged.

Optional Feature:
- Macro FAIRY_MEM_UNALIGNED_EN.
- Defined: LWL/LWR/SWL/SWR are supported.
  - Loads merge the selected bytes of dm_rdata into op1_i (old rt) per MIPS32 big/little-endian rules (little-endian fixed).
  - Stores: SWL be = 0001, 0011, 0111, 1111 for addr[1:0] = 0..3; SWR be = 1111, 1110, 1100, 1000.
  - These opcodes never raise an address error.
- Undefined: these four opcodes set illegal_inst_o=1, issue no request, and give reg_we_o=0.

Test Plan:
- ADDU result data_i=0x0000_0000_1234_5678, reg_we_i=1 -> next cycle data_o[31:0]=0x12345678, reg_we_o=1, stall_o never high.
- LB addr=0x1003, dm_rdata=0x80FF_FFFF, ack 3 cycles after req -> dm_addr=0x1000, stall_o high 4 cycles, data_o[31:0]=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr=0x2002, op1=0xAAAA_BEEF -> dm_wr=1, dm_be=1100, dm_wdata=0xBEEF_BEEF, reg_we_o=0.
- LW addr=0x3001 -> no dm_req, unaligned_addr_o=1, badvaddr_o=0x3001, reg_we_o=0.
- LW in WAIT, exception_i pulse before ack -> dm_req held until ack, data discarded, reg_we_o=0, next SW waits for drain.
- Reset_n low mid-WAIT -> dm_req=0 immediately, all outputs 0, late dm_ack ignored; with FAIRY_MEM_UNALIGNED_EN, LWL addr=0x4001, rdata=0x11223344, rt=0xAABBCCDD -> data_o=0x3344CCDD.

Source files
------------

// File: rtl/fairy_mem_stage.sv
// -----------------------------------------------------------------------------
// fairy_mem_stage
//   Memory-access pipeline stage between fairy_exe_stage and writeback.
//   Loads and stores run a req/ack transaction on the data-memory port. Load
//   data is lane-extracted and sign/zero extended. Everything is then
//   registered to writeback. Misaligned addresses raise an address error
//   without touching memory. stall_o holds upstream while a transaction is
//   outstanding.
//
//   Optional feature macro: FAIRY_MEM_UNALIGNED_EN
//     When defined, LWL/LWR/SWL/SWR are supported (little-endian merge rules).
//     When undefined, those opcodes are reported as illegal instructions.
//
//   Parameters
//     DM_TIMEOUT  cycles to wait for dm_ack before forcing completion with
//                 rdata = 0 (0 = wait forever)
//
//   Ports
//     clk, reset_n           clock, asynchronous active-low reset
//     exception_i, eret_i    pipeline flush
//     data_i[63:0]           execute result ([31:0] addr/ALU, [63:32] HI)
//     op1_i                  store data / old rt for LWL/LWR
//     inst_i, pc_i           instruction word and PC
//     reg_waddr_i, reg_we_i  destination register and write enable
//     hilo_we_i              HI/LO write enables
//     overflow_i, illegal_inst_i, delayslot_i   status flags from execute
//     dm_req/dm_wr/dm_addr/dm_be/dm_wdata      data-memory request (registered)
//     dm_ack, dm_rdata       data-memory acknowledge and read data
//     stall_o                hold upstream
//     *_o                    registered writeback outputs
//     unaligned_addr_o, badvaddr_o             address-error report
// -----------------------------------------------------------------------------
module fairy_mem_stage #(
  parameter int DM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exception_i,
  input  logic        eret_i,
  input  logic [63:0] data_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [1:0]  hilo_we_i,
  input  logic        overflow_i,
  input  logic        illegal_inst_i,
  input  logic        delayslot_i,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_o,
  output logic [63:0] data_o,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [1:0]  hilo_we_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        delayslot_o,
  output logic        overflow_o,
  output logic        illegal_inst_o,
  output logic        unaligned_addr_o,
  output logic [31:0] badvaddr_o
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  localparam logic [31:0] TIMEOUT_W = 32'(DM_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  // Store byte enables for a given opcode and byte offset.
  function automatic logic [3:0] store_be(input logic [5:0] opc, input logic [1:0] off);
    logic [3:0] be;
    be = 4'hF;
    case (opc)
      OP_SB:  be = 4'b0001 << off;
      OP_SH:  be = off[1] ? 4'b1100 : 4'b0011;
      OP_SWL: begin
        case (off)
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0011;
          2'd2:    be = 4'b0111;
          default: be = 4'b1111;
        endcase
      end
      OP_SWR: begin
        case (off)
          2'd0:    be = 4'b1111;
          2'd1:    be = 4'b1110;
          2'd2:    be = 4'b1100;
          default: be = 4'b1000;
        endcase
      end
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Store data steered onto the byte lanes selected by store_be.
  function automatic logic [31:0] store_wdata(input logic [5:0] opc, input logic [1:0] off,
                                              input logic [31:0] rt);
    logic [31:0] wd;
    wd = rt;
    case (opc)
      OP_SB:  wd = {4{rt[7:0]}};
      OP_SH:  wd = {2{rt[15:0]}};
      OP_SWL: begin
        case (off)
          2'd0:    wd = {24'h0, rt[31:24]};
          2'd1:    wd = {16'h0, rt[31:16]};
          2'd2:    wd = {8'h0,  rt[31:8]};
          default: wd = rt;
        endcase
      end
      OP_SWR: begin
        case (off)
          2'd0:    wd = rt;
          2'd1:    wd = {rt[23:0], 8'h0};
          2'd2:    wd = {rt[15:0], 16'h0};
          default: wd = {rt[7:0],  24'h0};
        endcase
      end
      default: wd = rt;
    endcase
    return wd;
  endfunction

  // Load data extraction / extension; LWL/LWR merge into the old rt value.
  function automatic logic [31:0] load_format(input logic [5:0] opc, input logic [1:0] off,
                                              input logic [31:0] rd, input logic [31:0] rt);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    shifted = rd >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rd[31:16] : rd[15:0];
    res     = rd;
    case (opc)
      OP_LB:  res = {{24{b[7]}}, b};
      OP_LBU: res = {24'h0, b};
      OP_LH:  res = {{16{h[15]}}, h};
      OP_LHU: res = {16'h0, h};
      OP_LWL: begin
        case (off)
          2'd0:    res = {rd[7:0],  rt[23:0]};
          2'd1:    res = {rd[15:0], rt[15:0]};
          2'd2:    res = {rd[23:0], rt[7:0]};
          default: res = rd;
        endcase
      end
      OP_LWR: begin
        case (off)
          2'd0:    res = rd;
          2'd1:    res = {rt[31:24], rd[31:8]};
          2'd2:    res = {rt[31:16], rd[31:16]};
          default: res = {rt[31:8],  rd[31:24]};
        endcase
      end
      default: res = rd;
    endcase
    return res;
  endfunction

  state_t      state_p1, state_d;
  logic [31:0] wait_cnt_p1;

  logic [5:0]  opc;
  logic [31:0] addr;
  logic [1:0]  off;
  logic        op_half, op_word, op_part;
  logic        part_ok, unsupported;
  logic        is_load, is_store, is_mem;
  logic        ill_eff, suppress, misalign, fault, mem_go;
  logic        flush, in_flight, timed_out, ack_eff, launch;
  logic [31:0] rdata_eff;

  assign opc  = inst_i[31:26];
  assign addr = data_i[31:0];
  assign off  = addr[1:0];

  assign op_half = (opc == OP_LH) | (opc == OP_LHU) | (opc == OP_SH);
  assign op_word = (opc == OP_LW) | (opc == OP_SW);
  assign op_part = (opc == OP_LWL) | (opc == OP_LWR) | (opc == OP_SWL) | (opc == OP_SWR);

`ifdef FAIRY_MEM_UNALIGNED_EN
  assign part_ok     = 1'b1;
  assign unsupported = 1'b0;
`else
  assign part_ok     = 1'b0;
  assign unsupported = op_part;
`endif

  assign is_load  = (opc == OP_LB) | (opc == OP_LBU) | (opc == OP_LH) | (opc == OP_LHU) |
                    (opc == OP_LW) | (part_ok & ((opc == OP_LWL) | (opc == OP_LWR)));
  assign is_store = (opc == OP_SB) | (opc == OP_SH) | (opc == OP_SW) |
                    (part_ok & ((opc == OP_SWL) | (opc == OP_SWR)));
  assign is_mem   = is_load | is_store;

  assign ill_eff  = illegal_inst_i | unsupported;
  assign suppress = ill_eff | overflow_i;
  assign misalign = (op_half & off[0]) | (op_word & (off != 2'b00));
  // Illegal/overflow take priority over the address error.
  assign fault    = is_mem & ~suppress & misalign;
  assign mem_go   = is_mem & ~suppress & ~misalign;

  assign flush     = exception_i | eret_i;
  assign in_flight = (state_p1 == WAIT) | (state_p1 == DRAIN);
  assign timed_out = (DM_TIMEOUT > 0) && (wait_cnt_p1 == TIMEOUT_W);
  assign ack_eff   = in_flight & (dm_ack | timed_out);
  // A forced completion without a real ack returns zero data.
  assign rdata_eff = dm_ack ? dm_rdata : 32'h0;
  assign launch    = (state_p1 == IDLE) & mem_go & ~flush;

  always_comb begin
    state_d = state_p1;
    stall_o = 1'b0;
    case (state_p1)
      IDLE: begin
        stall_o = mem_go & ~flush;
        if (mem_go && !flush) state_d = WAIT;
      end
      WAIT: begin
        stall_o = ~ack_eff;
        if (ack_eff)    state_d = IDLE;
        else if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        // A new memory op must wait for the abandoned access to retire.
        stall_o = mem_go & ~flush;
        if (ack_eff) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage 1: transaction control and data-memory port ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1    <= IDLE;
      wait_cnt_p1 <= 32'h0;
      dm_req      <= 1'b0;
      dm_wr       <= 1'b0;
      dm_addr     <= 32'h0;
      dm_be       <= 4'h0;
      dm_wdata    <= 32'h0;
    end else begin
      state_p1 <= state_d;
      if (launch) begin
        wait_cnt_p1 <= 32'h0;
        dm_req      <= 1'b1;
        dm_wr       <= is_store;
        dm_addr     <= {addr[31:2], 2'b00};
        dm_be       <= is_store ? store_be(opc, off) : 4'hF;
        dm_wdata    <= is_store ? store_wdata(opc, off, op1_i) : 32'h0;
      end else if (ack_eff) begin
        dm_req <= 1'b0;
      end else if (in_flight) begin
        wait_cnt_p1 <= wait_cnt_p1 + 32'd1;
      end
    end
  end

  // ---- stage 1: writeback output registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o           <= 64'h0;
      reg_waddr_o      <= 5'h0;
      reg_we_o         <= 1'b0;
      hilo_we_o        <= 2'h0;
      pc_o             <= 32'h0;
      inst_o           <= 32'h0;
      delayslot_o      <= 1'b0;
      overflow_o       <= 1'b0;
      illegal_inst_o   <= 1'b0;
      unaligned_addr_o <= 1'b0;
      badvaddr_o       <= 32'h0;
    end else if (flush || stall_o) begin
      // Flush and stalled cycles both emit an empty slot.
      data_o           <= 64'h0;
      reg_waddr_o      <= 5'h0;
      reg_we_o         <= 1'b0;
      hilo_we_o        <= 2'h0;
      pc_o             <= 32'h0;
      inst_o           <= 32'h0;
      delayslot_o      <= 1'b0;
      overflow_o       <= 1'b0;
      illegal_inst_o   <= 1'b0;
      unaligned_addr_o <= 1'b0;
      badvaddr_o       <= 32'h0;
    end else if (state_p1 == WAIT) begin
      // Transaction retiring; upstream inputs still describe this op.
      data_o           <= is_load ? {32'h0, load_format(opc, off, rdata_eff, op1_i)} : data_i;
      reg_waddr_o      <= reg_waddr_i;
      reg_we_o         <= reg_we_i & is_load;
      hilo_we_o        <= hilo_we_i;
      pc_o             <= pc_i;
      inst_o           <= inst_i;
      delayslot_o      <= delayslot_i;
      overflow_o       <= overflow_i;
      illegal_inst_o   <= ill_eff;
      unaligned_addr_o <= 1'b0;
      badvaddr_o       <= 32'h0;
    end else begin
      data_o           <= data_i;
      reg_waddr_o      <= reg_waddr_i;
      reg_we_o         <= reg_we_i & ~suppress & ~is_mem;
      hilo_we_o        <= hilo_we_i;
      pc_o             <= pc_i;
      inst_o           <= inst_i;
      delayslot_o      <= delayslot_i;
      overflow_o       <= overflow_i;
      illegal_inst_o   <= ill_eff;
      unaligned_addr_o <= fault;
      badvaddr_o       <= fault ? addr : 32'h0;
    end
  end

endmodule

// File: tb/tb_fairy_mem_stage.sv
module tb_fairy_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exception_i, eret_i;
  logic [63:0] data_i;
  logic [31:0] op1_i, inst_i, pc_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [1:0]  hilo_we_i;
  logic        overflow_i, illegal_inst_i, delayslot_i;
  logic        dm_req, dm_wr;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall_o;
  logic [63:0] data_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] pc_o, inst_o;
  logic        delayslot_o, overflow_o, illegal_inst_o, unaligned_addr_o;
  logic [31:0] badvaddr_o;

  fairy_mem_stage dut (
    .clk(clk), .reset_n(reset_n), .exception_i(exception_i), .eret_i(eret_i),
    .data_i(data_i), .op1_i(op1_i), .inst_i(inst_i), .pc_i(pc_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .hilo_we_i(hilo_we_i),
    .overflow_i(overflow_i), .illegal_inst_i(illegal_inst_i), .delayslot_i(delayslot_i),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_o(stall_o), .data_o(data_o),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .hilo_we_o(hilo_we_o),
    .pc_o(pc_o), .inst_o(inst_o), .delayslot_o(delayslot_o), .overflow_o(overflow_o),
    .illegal_inst_o(illegal_inst_o), .unaligned_addr_o(unaligned_addr_o),
    .badvaddr_o(badvaddr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        issue;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [63:0] data;
    logic        chk_data;
    logic        we;
    logic        unal;
    logic [31:0] bad;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [5:0]  opc;
    logic [63:0] din;
    logic [31:0] op1;
    logic [31:0] rdata;
    logic [3:0]  delay;
    logic        we_in;
    logic        ovf;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: derived from access size, byte offset and lane arithmetic.
  function automatic exp_t model(input logic [5:0] opc, input logic [63:0] din,
                                 input logic [31:0] op1, input logic [31:0] rdata,
                                 input logic we_in, input logic ovf, input logic ill_in);
    exp_t e;
    int size, off;
    bit ld, st, sgn, pl, pr, part;
    logic [63:0] mask, raw;
    logic [31:0] val;
    e = '0;
    off = int'(din[1:0]);
    size = 0; ld = 0; st = 0; sgn = 0; pl = 0; pr = 0;
    case (opc)
      6'h20: begin ld = 1; size = 1; sgn = 1; end
      6'h24: begin ld = 1; size = 1; end
      6'h21: begin ld = 1; size = 2; sgn = 1; end
      6'h25: begin ld = 1; size = 2; end
      6'h23: begin ld = 1; size = 4; end
      6'h28: begin st = 1; size = 1; end
      6'h29: begin st = 1; size = 2; end
      6'h2B: begin st = 1; size = 4; end
      6'h22: begin ld = 1; pl = 1; end
      6'h26: begin ld = 1; pr = 1; end
      6'h2A: begin st = 1; pl = 1; end
      6'h2E: begin st = 1; pr = 1; end
      default: ;
    endcase
    part = pl | pr;
`ifdef FAIRY_MEM_UNALIGNED_EN
    e.ill = ill_in;
`else
    e.ill = ill_in | part;
    if (part) begin ld = 0; st = 0; end
`endif
    if (!(ld || st)) begin
      e.data = din;
      e.chk_data = (size == 0) && !part;
      e.we = we_in & ~ovf & ~e.ill;
      return e;
    end
    if (e.ill || ovf) return e;
    if (size > 1 && (off % size) != 0) begin
      e.unal = 1'b1;
      e.bad = din[31:0];
      return e;
    end
    e.issue = 1'b1;
    e.wr = st;
    e.addr = din[31:0] & ~32'h3;
    if (st) begin
      e.chk_wdata = 1'b1;
      if (pl) begin
        e.be = 4'((1 << (off + 1)) - 1);
        e.wdata = op1 >> (8 * (3 - off));
      end else if (pr) begin
        e.be = 4'(15 << off);
        e.wdata = op1 << (8 * off);
      end else begin
        e.be = 4'(((1 << size) - 1) << off);
        e.wdata = (size == 1) ? op1[7:0] * 32'h0101_0101 :
                  (size == 2) ? op1[15:0] * 32'h0001_0001 : op1;
      end
    end else begin
      e.be = 4'hF;
      e.we = we_in;
      e.chk_data = 1'b1;
      if (pl)
        val = (rdata << (8 * (3 - off))) | (op1 & 32'(64'hFFFF_FFFF >> (8 * (off + 1))));
      else if (pr)
        val = (rdata >> (8 * off)) | (op1 & ~(32'hFFFF_FFFF >> (8 * off)));
      else begin
        mask = (64'h1 << (8 * size)) - 64'h1;
        raw = ({32'h0, rdata} >> (8 * off)) & mask;
        if (sgn && raw[8 * size - 1]) raw = raw | ~mask;
        val = raw[31:0];
      end
      e.data = {32'h0, val};
    end
    return e;
  endfunction

  // Applies one instruction at a negedge, plays memory with the given ack
  // delay, and checks the registered result at the negedge after it retires.
  task automatic run_op(input string nm, input logic [5:0] opc, input logic [63:0] din,
                        input logic [31:0] op1, input logic [31:0] rdata, input int delay,
                        input logic we_in, input logic ovf, input logic ill, input exp_t e);
    int stalls, rc;
    bit done;
    logic cap_wr;
    logic [31:0] cap_addr, cap_wdata, inst, pc;
    logic [3:0] cap_be;
    inst = {opc, 5'd4, 5'd2, 16'h0021};
    pc = $urandom;
    inst_i = inst; data_i = din; op1_i = op1; pc_i = pc;
    reg_we_i = we_in; overflow_i = ovf; illegal_inst_i = ill;
    reg_waddr_i = 5'd2; hilo_we_i = 2'b00; delayslot_i = 1'b0;
    stalls = 0; rc = 0; done = 0;
    cap_wr = 0; cap_addr = 0; cap_be = 0; cap_wdata = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (dm_req) begin
        rc++;
        if (rc == 1) begin
          cap_wr = dm_wr; cap_addr = dm_addr; cap_be = dm_be; cap_wdata = dm_wdata;
        end
      end
      dm_ack = dm_req && (rc == delay + 1);
      dm_rdata = dm_ack ? rdata : $urandom;
      #1;
      if (stall_o) stalls++;
      else done = 1;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    if (!done) begin
      bad++; total++;
      $display("FAIL %s.timeout: stall_o still high after 64 cycles", nm);
    end
    chk({nm, ".issue"}, 64'(rc > 0), 64'(e.issue));
    chk({nm, ".stalls"}, 64'(stalls), e.issue ? 64'(delay + 1) : 64'd0);
    if (e.issue) begin
      chk({nm, ".dm_wr"}, 64'(cap_wr), 64'(e.wr));
      chk({nm, ".dm_addr"}, 64'(cap_addr), 64'(e.addr));
      chk({nm, ".dm_be"}, 64'(cap_be), 64'(e.be));
      if (e.chk_wdata) chk({nm, ".dm_wdata"}, 64'(cap_wdata), 64'(e.wdata));
    end
    chk({nm, ".req_after"}, 64'(dm_req), 64'd0);
    chk({nm, ".reg_we"}, 64'(reg_we_o), 64'(e.we));
    chk({nm, ".unal"}, 64'(unaligned_addr_o), 64'(e.unal));
    chk({nm, ".illegal"}, 64'(illegal_inst_o), 64'(e.ill));
    chk({nm, ".overflow"}, 64'(overflow_o), 64'(ovf));
    chk({nm, ".inst"}, 64'(inst_o), 64'(inst));
    chk({nm, ".pc"}, 64'(pc_o), 64'(pc));
    if (e.unal) chk({nm, ".badvaddr"}, 64'(badvaddr_o), 64'(e.bad));
    if (e.chk_data) chk({nm, ".data"}, data_o, e.data);
  endtask

  task automatic drive_nop();
    inst_i = 32'h0; data_i = 64'h0; op1_i = 32'h0; pc_i = 32'h0;
    reg_we_i = 1'b0; overflow_i = 1'b0; illegal_inst_i = 1'b0;
    reg_waddr_i = 5'h0; hilo_we_i = 2'h0; delayslot_i = 1'b0;
  endtask

  localparam int NV = 13;
  vec_t tbl [NV];
  logic [5:0] ops [13];

  initial begin
    logic [31:0] sw_inst;
    exp_t e;
    logic [5:0] opc;
    logic [63:0] din;
    logic [31:0] op1, rd;
    logic we_in, ovf, ill;

    //            opc    din                     op1           rdata         dly we ovf  {issue wr addr be wdata cw data cd we unal bad ill}
    tbl[0]  = '{6'h00, 64'h0000_0000_1234_5678, 32'h0,        32'h0,        4'd0, 1, 0, '{0,0,32'h0,4'h0,32'h0,0,64'h0000_0000_1234_5678,1,1,0,32'h0,0}};
    tbl[1]  = '{6'h20, 64'hDEAD_BEEF_0000_1003, 32'h0,        32'h80FF_FFFF,4'd3, 1, 0, '{1,0,32'h1000,4'hF,32'h0,0,64'h0000_0000_FFFF_FF80,1,1,0,32'h0,0}};
    tbl[2]  = '{6'h24, 64'hDEAD_BEEF_0000_1003, 32'h0,        32'h80FF_FFFF,4'd3, 1, 0, '{1,0,32'h1000,4'hF,32'h0,0,64'h0000_0000_0000_0080,1,1,0,32'h0,0}};
    tbl[3]  = '{6'h29, 64'h0000_0000_0000_2002, 32'hAAAA_BEEF,32'h0,        4'd1, 1, 0, '{1,1,32'h2000,4'hC,32'hBEEF_BEEF,1,64'h0,0,0,0,32'h0,0}};
    tbl[4]  = '{6'h23, 64'h0000_0000_0000_3001, 32'h0,        32'h0,        4'd0, 1, 0, '{0,0,32'h0,4'h0,32'h0,0,64'h0,0,0,1,32'h3001,0}};
    tbl[5]  = '{6'h21, 64'h0000_0000_0000_1002, 32'h0,        32'h8001_1234,4'd0, 1, 0, '{1,0,32'h1000,4'hF,32'h0,0,64'h0000_0000_FFFF_8001,1,1,0,32'h0,0}};
    tbl[6]  = '{6'h25, 64'h0000_0000_0000_1000, 32'h0,        32'h8001_F234,4'd2, 1, 0, '{1,0,32'h1000,4'hF,32'h0,0,64'h0000_0000_0000_F234,1,1,0,32'h0,0}};
    tbl[7]  = '{6'h28, 64'h0000_0000_0000_2001, 32'h1234_56AB,32'h0,        4'd1, 1, 0, '{1,1,32'h2000,4'h2,32'hABAB_ABAB,1,64'h0,0,0,0,32'h0,0}};
    tbl[8]  = '{6'h2B, 64'h0000_0000_0000_2004, 32'hCAFE_F00D,32'h0,        4'd0, 1, 0, '{1,1,32'h2004,4'hF,32'hCAFE_F00D,1,64'h0,0,0,0,32'h0,0}};
    tbl[9]  = '{6'h23, 64'h0000_0000_0000_3008, 32'h0,        32'h89AB_CDEF,4'd1, 1, 0, '{1,0,32'h3008,4'hF,32'h0,0,64'h0000_0000_89AB_CDEF,1,1,0,32'h0,0}};
    tbl[10] = '{6'h21, 64'h0000_0000_0000_3003, 32'h0,        32'h0,        4'd0, 1, 0, '{0,0,32'h0,4'h0,32'h0,0,64'h0,0,0,1,32'h3003,0}};
    tbl[11] = '{6'h00, 64'h0000_0001_FFFF_FFFF, 32'h0,        32'h0,        4'd0, 1, 1, '{0,0,32'h0,4'h0,32'h0,0,64'h0000_0001_FFFF_FFFF,1,0,0,32'h0,0}};
`ifdef FAIRY_MEM_UNALIGNED_EN
    tbl[12] = '{6'h22, 64'h0000_0000_0000_4001, 32'hAABB_CCDD,32'h1122_3344,4'd1, 1, 0, '{1,0,32'h4000,4'hF,32'h0,0,64'h0000_0000_3344_CCDD,1,1,0,32'h0,0}};
`else
    tbl[12] = '{6'h22, 64'h0000_0000_0000_4001, 32'hAABB_CCDD,32'h1122_3344,4'd1, 1, 0, '{0,0,32'h0,4'h0,32'h0,0,64'h0,0,0,0,32'h0,1}};
`endif
    ops = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
            6'h22, 6'h26, 6'h2A, 6'h2E};

    reset_n = 1'b0; exception_i = 1'b0; eret_i = 1'b0;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    drive_nop();
    @(negedge clk); @(negedge clk);
    chk("rst.dm_req", 64'(dm_req), 64'd0);
    chk("rst.data", data_o, 64'h0);
    chk("rst.reg_we", 64'(reg_we_o), 64'd0);
    chk("rst.pc", 64'(pc_o), 64'd0);
    chk("rst.flags", 64'({hilo_we_o, delayslot_o, overflow_o, illegal_inst_o, unaligned_addr_o}), 64'd0);
    chk("rst.stall", 64'(stall_o), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), tbl[i].opc, tbl[i].din, tbl[i].op1, tbl[i].rdata,
             int'(tbl[i].delay), tbl[i].we_in, tbl[i].ovf, 1'b0, tbl[i].e);

    // Flush while waiting: access drains, data discarded, following SW waits.
    inst_i = {6'h23, 26'h0}; data_i = 64'h3000; op1_i = 32'h0; reg_we_i = 1'b1;
    @(negedge clk);
    chk("fl.req", 64'(dm_req), 64'd1);
    exception_i = 1'b1;
    @(negedge clk);
    exception_i = 1'b0;
    sw_inst = {6'h2B, 26'h0};
    inst_i = sw_inst; data_i = 64'h5000; op1_i = 32'h1111_2222; reg_we_i = 1'b0;
    #1;
    chk("fl.req_held", 64'(dm_req), 64'd1);
    chk("fl.addr_held", 64'(dm_addr), 64'h3000);
    chk("fl.wr_held", 64'(dm_wr), 64'd0);
    chk("fl.sw_waits", 64'(stall_o), 64'd1);
    chk("fl.we_cleared", 64'(reg_we_o), 64'd0);
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fl.drain_stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    chk("fl.req_dropped", 64'(dm_req), 64'd0);
    chk("fl.discard_we", 64'(reg_we_o), 64'd0);
    chk("fl.discard_inst", 64'(inst_o), 64'd0);
    chk("fl.sw_start", 64'(stall_o), 64'd1);
    @(negedge clk);
    chk("fl.sw_req", 64'(dm_req), 64'd1);
    chk("fl.sw_wr", 64'(dm_wr), 64'd1);
    chk("fl.sw_addr", 64'(dm_addr), 64'h5000);
    chk("fl.sw_wdata", 64'(dm_wdata), 64'h1111_2222);
    dm_ack = 1'b1;
    #1;
    chk("fl.sw_ack_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    dm_ack = 1'b0;
    chk("fl.sw_done_req", 64'(dm_req), 64'd0);
    chk("fl.sw_done_inst", 64'(inst_o), 64'(sw_inst));

    // Reset asserted mid-transaction; a late ack must be ignored.
    inst_i = {6'h23, 26'h0}; data_i = 64'h3000; reg_we_i = 1'b1;
    @(negedge clk);
    chk("rw.req", 64'(dm_req), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw.req_async", 64'(dm_req), 64'd0);
    chk("rw.data", data_o, 64'h0);
    chk("rw.inst", 64'(inst_o), 64'd0);
    drive_nop();
    dm_ack = 1'b1; dm_rdata = 32'hABCD_1234;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("rw.late_ack_req", 64'(dm_req), 64'd0);
    chk("rw.late_ack_we", 64'(reg_we_o), 64'd0);
    chk("rw.late_ack_data", data_o, 64'h0);
    chk("rw.stall", 64'(stall_o), 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      opc = ops[$urandom_range(0, 12)];
      din = {$urandom, $urandom};
      op1 = $urandom;
      rd = $urandom;
      we_in = 1'($urandom);
      ovf = ($urandom_range(0, 7) == 0);
      ill = ($urandom_range(0, 7) == 0);
      e = model(opc, din, op1, rd, we_in, ovf, ill);
      run_op($sformatf("rnd%0d", i), opc, din, op1, rd, $urandom_range(0, 4),
             we_in, ovf, ill, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
